// File: rtl/ai_density_engine_if.sv
// rtl/ai_density_engine_if.sv - memory-mapped slave bus for the density targeting engine
interface ai_density_engine_if #(
    parameter int GRID = 10
);
    logic [1:0]           addr;
    logic                 write_en;
    logic [GRID*GRID-1:0] data_in;
    logic                 wait_request;
    logic [GRID*GRID+3:0] data_out;

    modport master (output addr, write_en, data_in, input wait_request, data_out);
    modport slave  (input addr, write_en, data_in, output wait_request, data_out);
endinterface

// File: rtl/ai_density_engine.sv
// rtl/ai_density_engine.sv - placement-density targeting engine; AI_HUNT_BOOST_EN enables hit-adjacent weighting
module ai_density_engine #(
    parameter int                     GRID       = 10,
    parameter int                     NUM_SHIPS  = 5,
    parameter logic [4*NUM_SHIPS-1:0] SHIP_LENS  = {4'd2, 4'd3, 4'd3, 4'd4, 4'd5},
    parameter int                     CW         = 8,
    parameter int                     HIT_WEIGHT = 4
) (
    input  logic             clock,
    input  logic             reset,
    ai_density_engine_if.slave bus
);
    localparam int N  = GRID * GRID;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(GRID + 1);
    localparam int SW = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1;
    localparam int WW = CW + 16;
`ifdef AI_HUNT_BOOST_EN
    localparam int BOOST_ON = 1;
`else
    localparam int BOOST_ON = 0;
`endif
    localparam int             BOOST = HIT_WEIGHT * BOOST_ON;
    localparam logic [CW-1:0]  CMAX  = '1;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_PLACE, S_SCAN, S_DONE} state_t;

    state_t               state;
    logic [N-1:0]         fired;
    logic [N-1:0]         hit;
    logic [NUM_SHIPS-1:0] ships;
    logic [CW-1:0]        cnt      [N];
    logic [CW-1:0]        cnt_next [N];
    logic [SW-1:0]        ship_idx;
    logic                 orient;
    logic [RW-1:0]        org_row;
    logic [RW-1:0]        org_col;
    logic [IW-1:0]        scan_idx;
    logic [IW-1:0]        best_idx;
    logic [CW-1:0]        best_val;
    logic                 found;
    logic                 res_valid;
    logic [IW-1:0]        res_idx;
    logic [CW-1:0]        res_max;
    logic                 wait_r;
    logic                 to_idle;

    logic [3:0]           cur_len;
    logic [N-1:0]         span;
    logic                 fits;
    logic                 cand_ok;
    int                   hit_cnt;
    logic [WW-1:0]        weight;
    logic                 scan_better;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [WW-1:0] w);
        logic [WW-1:0] s;
        s = WW'(a) + w;
        return (s > WW'(CMAX)) ? CMAX : s[CW-1:0];
    endfunction

    assign cur_len = SHIP_LENS[4*ship_idx +: 4];

    // Cells covered by the current candidate, clipped at the board edge.
    always_comb begin
        span = '0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                if (orient)
                    span[r*GRID+c] = (c == int'(org_col)) && (r >= int'(org_row)) &&
                                     (r < int'(org_row) + int'(cur_len));
                else
                    span[r*GRID+c] = (r == int'(org_row)) && (c >= int'(org_col)) &&
                                     (c < int'(org_col) + int'(cur_len));
            end
        end
    end

    always_comb begin
        hit_cnt = 0;
        for (int i = 0; i < N; i++)
            if (span[i] && hit[i]) hit_cnt = hit_cnt + 1;
    end

    assign fits    = orient ? (int'(org_row) + int'(cur_len) <= GRID)
                            : (int'(org_col) + int'(cur_len) <= GRID);
    assign cand_ok = ships[ship_idx] && fits && ((span & fired & ~hit) == '0);
    assign weight  = WW'(1 + BOOST * hit_cnt);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = cnt[i];
            if (cand_ok && span[i] && !fired[i]) cnt_next[i] = sat_add(cnt[i], weight);
        end
    end

    // Strict compare keeps the lowest index on ties.
    assign scan_better = !fired[scan_idx] && (!found || (cnt[scan_idx] > best_val));

    always_comb begin
        bus.data_out = '0;
        case (bus.addr)
            2'd0:    bus.data_out[CW+IW:0]        = {res_valid, res_idx, res_max};
            2'd1:    bus.data_out[N-1:0]          = fired;
            2'd2:    bus.data_out[N-1:0]          = hit;
            default: bus.data_out[NUM_SHIPS-1:0]  = ships;
        endcase
    end

    assign bus.wait_request = wait_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_CLEAR;
            fired     <= '0;
            hit       <= '0;
            ships     <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            ship_idx  <= '0;
            orient    <= 1'b0;
            org_row   <= '0;
            org_col   <= '0;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            found     <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_max   <= '0;
            wait_r    <= 1'b1;
            to_idle   <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    for (int i = 0; i < N; i++) cnt[i] <= '0;
                    ship_idx <= '0;
                    orient   <= 1'b0;
                    org_row  <= '0;
                    org_col  <= '0;
                    scan_idx <= '0;
                    best_idx <= '0;
                    best_val <= '0;
                    found    <= 1'b0;
                    if (to_idle) begin
                        state  <= S_IDLE;
                        wait_r <= 1'b0;
                    end else begin
                        state  <= S_PLACE;
                    end
                end
                S_IDLE: begin
                    if (bus.write_en) begin
                        case (bus.addr)
                            2'd0: begin
                                res_valid <= 1'b0;
                                res_idx   <= '0;
                                res_max   <= '0;
                                to_idle   <= 1'b0;
                                wait_r    <= 1'b1;
                                state     <= S_CLEAR;
                            end
                            2'd1:    fired <= bus.data_in;
                            2'd2:    hit   <= bus.data_in;
                            default: ships <= bus.data_in[NUM_SHIPS-1:0];
                        endcase
                    end
                end
                S_PLACE: begin
                    for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
                    // Origin index is the inner loop, then orientation, then ship.
                    if (org_col == RW'(GRID - 1)) begin
                        org_col <= '0;
                        if (org_row == RW'(GRID - 1)) begin
                            org_row <= '0;
                            if (orient) begin
                                orient <= 1'b0;
                                if (ship_idx == SW'(NUM_SHIPS - 1)) state <= S_SCAN;
                                else ship_idx <= ship_idx + 1'b1;
                            end else begin
                                orient <= 1'b1;
                            end
                        end else begin
                            org_row <= org_row + 1'b1;
                        end
                    end else begin
                        org_col <= org_col + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (scan_better) begin
                        found    <= 1'b1;
                        best_idx <= scan_idx;
                        best_val <= cnt[scan_idx];
                    end
                    if (scan_idx == IW'(N - 1)) state <= S_DONE;
                    else scan_idx <= scan_idx + 1'b1;
                end
                S_DONE: begin
                    res_valid <= found;
                    res_idx   <= found ? best_idx : '1;
                    res_max   <= found ? best_val : '0;
                    wait_r    <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_ai_density_engine.sv
// tb/tb_ai_density_engine.sv - directed bench with placement-enumeration model for two counter widths
module tb_ai_density_engine;
    localparam int GRID       = 10;
    localparam int N          = GRID * GRID;
    localparam int DW         = N + 4;
    localparam int IW         = 7;
    localparam int HIT_WEIGHT = 4;
    localparam int LAT        = 1 + 5 * 2 * N + N + 1;
`ifdef AI_HUNT_BOOST_EN
    localparam int HUNT_MAX = 26;
`else
    localparam int HUNT_MAX = 10;
`endif

    logic          clock;
    logic          reset;
    logic [1:0]    addr;
    logic          write_en;
    logic [N-1:0]  data_in;

    int n_checks = 0;
    int n_err    = 0;
    logic last_wait;

    ai_density_engine_if #(.GRID(GRID)) bus8 ();
    ai_density_engine_if #(.GRID(GRID)) bus3 ();

    assign bus8.addr     = addr;
    assign bus8.write_en = write_en;
    assign bus8.data_in  = data_in;
    assign bus3.addr     = addr;
    assign bus3.write_en = write_en;
    assign bus3.data_in  = data_in;

    ai_density_engine #(.GRID(GRID), .CW(8), .HIT_WEIGHT(HIT_WEIGHT)) dut8 (
        .clock(clock), .reset(reset), .bus(bus8.slave));
    ai_density_engine #(.GRID(GRID), .CW(3), .HIT_WEIGHT(HIT_WEIGHT)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] pack(input int cw, input int v, input int b, input int m);
        return (DW'(v) << (cw + IW)) | (DW'(b) << cw) | DW'(m);
    endfunction

    // Enumerate every placement directly on the grid and pick the densest unfired cell.
    function automatic logic [DW-1:0] model_result(input int cw, input logic [N-1:0] fm,
                                                  input logic [N-1:0] hm, input logic [4:0] sm);
        int dens [N];
        int lens [5];
        int cap, best, bv, ok, kh, w, rr, cc, idx;
        lens = '{5, 4, 3, 3, 2};
        cap = (1 << cw) - 1;
        for (int i = 0; i < N; i++) dens[i] = 0;
        for (int s = 0; s < 5; s++) begin
            if (!sm[s]) continue;
            for (int o = 0; o < 2; o++)
                for (int r = 0; r < GRID; r++)
                    for (int c = 0; c < GRID; c++) begin
                        ok = 1; kh = 0;
                        for (int k = 0; k < lens[s]; k++) begin
                            rr = r + (o == 1 ? k : 0);
                            cc = c + (o == 1 ? 0 : k);
                            if (rr >= GRID || cc >= GRID) ok = 0;
                            else begin
                                idx = rr * GRID + cc;
                                if (fm[idx] && !hm[idx]) ok = 0;
                                if (hm[idx]) kh++;
                            end
                        end
                        if (ok == 0) continue;
`ifdef AI_HUNT_BOOST_EN
                        w = 1 + HIT_WEIGHT * kh;
`else
                        w = 1;
`endif
                        for (int k = 0; k < lens[s]; k++) begin
                            idx = (r + (o == 1 ? k : 0)) * GRID + c + (o == 1 ? 0 : k);
                            if (!fm[idx]) dens[idx] = (dens[idx] + w > cap) ? cap : dens[idx] + w;
                        end
                    end
        end
        best = -1; bv = 0;
        for (int i = 0; i < N; i++)
            if (!fm[i] && (best < 0 || dens[i] > bv)) begin
                best = i; bv = dens[i];
            end
        if (best < 0) return pack(cw, 0, 127, 0);
        return pack(cw, 1, best, bv);
    endfunction

    logic [N-1:0]  m_fired, m_hit;
    logic [4:0]    m_ships;
    logic [DW-1:0] m_res8, m_res3, p8, p3;
    int            m_busy_left;
    logic          m_pend;

    always @(posedge clock) begin
        if (reset) begin
            m_fired <= '0; m_hit <= '0; m_ships <= '0;
            m_res8 <= '0; m_res3 <= '0;
            m_busy_left <= 1; m_pend <= 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left <= m_busy_left - 1;
            if (m_busy_left == 1 && m_pend) begin
                m_res8 <= p8; m_res3 <= p3; m_pend <= 1'b0;
            end
        end else if (write_en) begin
            case (addr)
                2'd0: begin
                    m_res8 <= '0; m_res3 <= '0;
                    p8 <= model_result(8, m_fired, m_hit, m_ships);
                    p3 <= model_result(3, m_fired, m_hit, m_ships);
                    m_pend <= 1'b1;
                    m_busy_left <= LAT;
                end
                2'd1:    m_fired <= data_in;
                2'd2:    m_hit   <= data_in;
                default: m_ships <= data_in[4:0];
            endcase
        end
    end

    function automatic logic [DW-1:0] readback(input logic [DW-1:0] res);
        case (addr)
            2'd0:    return res;
            2'd1:    return DW'(m_fired);
            2'd2:    return DW'(m_hit);
            default: return DW'(m_ships);
        endcase
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic compare_all();
        check("wait8", DW'(bus8.wait_request), DW'(m_busy_left > 0));
        check("wait3", DW'(bus3.wait_request), DW'(m_busy_left > 0));
        check("dout8", bus8.data_out, readback(m_res8));
        check("dout3", bus3.data_out, readback(m_res3));
    endtask

    task automatic tick();
        @(negedge clock);
        compare_all();
        last_wait = bus8.wait_request;
        @(posedge clock);
        #2;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [N-1:0] d);
        addr = a; data_in = d; write_en = 1'b1;
        tick();
        write_en = 1'b0; addr = 2'd0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            tick();
            if (last_wait) cyc++;
        end while (last_wait && cyc < 3000);
        check("wait_timeout", DW'(last_wait), DW'(0));
    endtask

    task automatic run(output int cyc);
        write_reg(2'd0, '0);
        wait_idle(cyc);
        addr = 2'd0;
        #1;
    endtask

    int            cyc;
    logic [N-1:0]  v;
    logic [N-1:0]  pat_f;
    logic [N-1:0]  pat_h;
    int            f_list [9];
    int            h_list [3];

    initial begin
        reset = 1'b1; addr = 2'd0; write_en = 1'b0; data_in = '0;
        f_list = '{0, 11, 22, 33, 50, 51, 52, 77, 98};
        h_list = '{51, 52, 77};
        @(posedge clock);
        #2;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rst_wait", DW'(bus8.wait_request), DW'(0));
        check("rst_res", bus8.data_out, DW'(0));

        write_reg(2'd3, N'(1));
        run(cyc);
        check("lat_empty", DW'(cyc), DW'(1102));
        check("empty8", bus8.data_out, pack(8, 1, 44, 10));
        check("empty_sat3", bus3.data_out, pack(3, 1, 14, 7));

        v = '1; v[0] = 1'b0;
        write_reg(2'd1, v);
        write_reg(2'd3, N'(5'b11111));
        run(cyc);
        check("one_free8", bus8.data_out, pack(8, 1, 0, 0));
        check("one_free3", bus3.data_out, pack(3, 1, 0, 0));

        write_reg(2'd1, '1);
        run(cyc);
        check("all_fired8", bus8.data_out, pack(8, 0, 127, 0));
        check("all_fired3", bus3.data_out, pack(3, 0, 127, 0));

        v = '0; v[44] = 1'b1;
        write_reg(2'd1, v);
        write_reg(2'd2, v);
        write_reg(2'd3, N'(1));
        run(cyc);
        check("hunt8", bus8.data_out, pack(8, 1, 45, HUNT_MAX));

        pat_f = '0; pat_h = '0;
        foreach (f_list[i]) pat_f[f_list[i]] = 1'b1;
        foreach (h_list[i]) pat_h[h_list[i]] = 1'b1;
        write_reg(2'd1, pat_f);
        write_reg(2'd2, pat_h);
        write_reg(2'd3, N'(5'b10110));
        write_reg(2'd0, '0);
        write_reg(2'd1, '1);
        write_reg(2'd0, '0);
        wait_idle(cyc);
        check("lat_busy_ignored", DW'(cyc), DW'(1100));
        addr = 2'd1;
        #1;
        check("fired_kept", bus8.data_out, DW'(pat_f));
        addr = 2'd0;
        tick();

        write_reg(2'd0, '0);
        repeat (501) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("abort_wait", DW'(bus8.wait_request), DW'(0));
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check("abort_regs", bus8.data_out, DW'(0));
        end
        write_reg(2'd3, N'(1));
        run(cyc);
        check("lat_restart", DW'(cyc), DW'(1102));
        check("restart8", bus8.data_out, pack(8, 1, 44, 10));
        check("restart3", bus3.data_out, pack(3, 1, 14, 7));
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/ai_density_engine.md
Name: ai_density_engine

Overview:
- Parametrised successor to the single-board targeting AI, for the BattleChip CPU.
- Memory-mapped slave with the same addr/write_en/data_in/wait_request/data_out contract.
- Software loads the fired mask, hit mask and remaining-ship mask, then writes a start. The block enumerates every legal ship placement, accumulates a per-cell density, and returns the highest-density unfired cell.
- Grid size, ship set and counter width are generic; hit-adjacent weighting is an optional build feature.

Parameters:
GRID, 10, board edge length; cells = GRID*GRID, index = row*GRID+col
NUM_SHIPS, 5, number of ship types
SHIP_LENS, {4'd2,4'd3,4'd3,4'd4,4'd5}, packed lengths; ship s length = SHIP_LENS[4s+:4]
CW, 8, per-cell density counter width (saturating)
HIT_WEIGHT, 4, extra weight per covered hit cell (only with AI_HUNT_BOOST_EN)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
addr  in  2  register select
write_en  in  1  write strobe
data_in  in  GRID*GRID  write data
wait_request  out  1  high = busy; master must hold the request
data_out  out  GRID*GRID+4  read data, combinational on addr

Behaviour:
- Register map:
  - addr0 write = start (data ignored); addr0 read = {valid, best_index[IW-1:0], max_count[CW-1:0]}, zero-extended; IW = $clog2(GRID*GRID).
  - addr1 = fired mask; addr2 = hit mask (hit implies fired).
  - addr3 = ship-alive mask in data_in[NUM_SHIPS-1:0]; ship s is enumerated only if its bit is 1.
  - addr1-3 read back their stored values.
  - Constraint: CW+IW+1 <= GRID*GRID+4.
- Reset (sync):
  - All registers, masks, counters and result fields go to 0; wait_request=1; state=CLEAR.
  - Asserting reset mid-computation aborts immediately with identical results.
- States:
  - CLEAR: all counters zeroed in 1 cycle -> PLACE, or -> IDLE after a reset.
  - IDLE: wait_request=0. Write to addr1-3 stores data. Write to addr0 clears the result and -> CLEAR (wait_request=1 from the next cycle).
  - PLACE: one candidate per cycle. Loops are ship s (0..NUM_SHIPS-1, outer), orientation o (0 horizontal, 1 vertical), origin index 0..GRID*GRID-1 (inner). Every candidate consumes a cycle, including dead ships and candidates that do not fit, so the cycle count is fixed.
    - Candidate is valid iff the ship is alive, the span fits on the board (no row wrap), and no span cell is a miss (fired & ~hit).
    - Valid candidate: weight w is added to each unfired cell in the span. w = 1, or 1+HIT_WEIGHT*(hits covered) with the feature enabled.
    - Counters saturate at 2^CW-1.
  - SCAN: one cell per cycle, index 0..GRID*GRID-1. Tracks the max over unfired cells only; strict greater-than, so the lowest index wins ties.
  - DONE: latch the result (1 cycle) -> IDLE.
- Result fields:
  - valid=1 if any cell is unfired; best_index = winning cell (lowest unfired index if all counts are 0).
  - If all cells are fired: valid=0, best_index = all ones, max_count=0.
- Latency:
  - wait_request is high for exactly 1 + NUM_SHIPS*2*GRID*GRID + GRID*GRID + 1 cycles after the start-accept edge; 1102 at defaults.
- Access while busy:
  - Reads/writes while wait_request=1 are ignored (not stored).
  - data_out addr0 returns 0 until DONE.
  - A start write while busy is not queued.

Optional Feature:
- AI_HUNT_BOOST_EN:
  - Defined: valid placements covering k hit cells add 1+HIT_WEIGHT*k to each unfired span cell.
  - Undefined: every valid placement adds 1; hits are treated only as non-blocking fired cells.
- Latency is identical in both builds.

Test Plan:
- Reset held 2 cycles then released -> wait_request=1 through the CLEAR cycle, 0 afterwards; data_out addr0 = 0.
- Defaults, empty board, ships=5'b00001 (len 5), start:
  - wait_request high exactly 1102 cycles.
  - addr0: valid=1, best_index=44, max_count=10.
- Fired = all cells except cell 0, hit=0, ships=5'b11111 -> valid=1, best_index=0, max_count=0. Fired = all ones -> valid=0, best_index=127 (IW=7), max_count=0.
- Fired=hit=cell 44, ships=5'b00001:
  - With AI_HUNT_BOOST_EN (HIT_WEIGHT=4) -> best_index=45, max_count=26.
  - Without the feature -> best_index=45, max_count=10.
- CW=3, empty board, ships=5'b00001 -> counters saturate at 7; best_index=14, max_count=7.
- Start, then reset asserted at PLACE cycle 500 -> all outputs 0, wait_request=1 for one cycle then 0; masks read back 0; a fresh start then completes normally.
